// File: rtl/barcode_pkg.sv
// Shared types and constants for the serial barcode station-ID decoder.
package barcode_pkg;

    localparam int unsigned CNT_W_DEF = 22;
    localparam int unsigned ID_W_DEF  = 8;

    // Station IDs must have both top bits clear.
    localparam logic [ID_W_DEF-1:0] VALID_MASK = 8'hC0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_FALL,
        SAMPLE
    } state_e;

endpackage

// File: rtl/barcode_if.sv
// Sensor/consumer side of the barcode decoder: raw BC line in, station ID out.
interface barcode_if
    import barcode_pkg::*;
#(
    parameter int unsigned ID_W = ID_W_DEF
) ();

    logic            BC;
    logic            clr_ID_vld;
    logic [ID_W-1:0] ID;
    logic            ID_vld;

    modport master (
        output BC,
        output clr_ID_vld,
        input  ID,
        input  ID_vld
    );

    modport slave (
        input  BC,
        input  clr_ID_vld,
        output ID,
        output ID_vld
    );

endinterface

// File: rtl/barcode_bc_sync.sv
// Two-flop synchroniser for the async BC line plus a history flop for falling-edge detect.
module barcode_bc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bc_i,
    output logic bc_s_o,
    output logic fall_c_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Preset high so an idle line never produces a spurious edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= bc_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign bc_s_o   = s2_q;
    assign fall_c_o = s3_q & ~s2_q;

endmodule

// File: rtl/barcode.sv
// Serial barcode decoder: start-bit low time sets T, each data bit sampled T clks after its fall.
// Optional BARCODE_TIMEOUT_EN aborts a frame left idle in WAIT_FALL for TIMEOUT clks.
module barcode
    import barcode_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
`ifdef BARCODE_TIMEOUT_EN
    ,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(22'h3FFFFF)
`endif
) (
    input  logic     clk,
    input  logic     rst_n,
    barcode_if.slave bus
);

    localparam int unsigned BIT_W = $clog2(ID_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic bc_s;
    logic fall;

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  period_q,  period_d;
    logic [CNT_W-1:0]  tcnt_q,    tcnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]   shreg_q,   shreg_d;
    logic              commit_q,  commit_d;
    logic [ID_W-1:0]   id_q,      id_d;
    logic              id_vld_q,  id_vld_d;

    barcode_bc_sync u_bc_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .bc_i     (bus.BC),
        .bc_s_o   (bc_s),
        .fall_c_o (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            period_q  <= '0;
            tcnt_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            commit_q  <= 1'b0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            tcnt_q    <= tcnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            commit_q  <= commit_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
        end
    end

    // Frame FSM: measure T on the start bit, then one sample per data bit.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        tcnt_d    = tcnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        commit_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    period_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (!bc_s) begin
                    if (period_q != CNT_MAX) begin
                        period_d = period_q + CNT_W'(1);
                    end
                end else begin
                    bit_cnt_d = '0;
                    tcnt_d    = '0;
                    state_d   = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    tcnt_d  = '0;
                    state_d = SAMPLE;
                end
`ifdef BARCODE_TIMEOUT_EN
                else if (tcnt_q == TIMEOUT) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
`endif
            end
            SAMPLE: begin
                // Edges during SAMPLE are ignored; only the T-clk mark matters.
                if (tcnt_q == period_q) begin
                    shreg_d   = {shreg_q[ID_W-2:0], bc_s};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    tcnt_d    = '0;
                    if (bit_cnt_q == BIT_W'(ID_W - 1)) begin
                        commit_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_FALL;
                    end
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers: a valid commit beats a same-cycle clear.
    always_comb begin
        id_d     = id_q;
        id_vld_d = id_vld_q;
        if (bus.clr_ID_vld) begin
            id_vld_d = 1'b0;
        end
        if (commit_q && ((shreg_q & ID_W'(VALID_MASK)) == '0)) begin
            id_d     = shreg_q;
            id_vld_d = 1'b1;
        end
    end

    assign bus.ID     = id_q;
    assign bus.ID_vld = id_vld_q;

endmodule
